// File: rtl/mem_ctrl.sv
// mem_ctrl: byte-serial bridge from IF fetches and MEM loads/stores to an 8-bit RAM port.
// Latency: n-byte read completes (done) n+2 cycles after sampling; n-byte write after n+1.
// Backpressure: requests held until done; rdy=0 freezes state (reads restart, writes resume).
// Ports: clk/rst; rdy global freeze; jump flushes IF; if_* fetch side; mem_* load/store side;
//        ram_a/ram_dout/ram_wr drive the RAM, ram_din returns the byte addressed one edge earlier.
module mem_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_inst,
  output logic        if_done,
  output logic        if_stall,
  input  logic        mem_req,
  input  logic        mem_we,
  input  logic [1:0]  mem_size,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_rdata,
  output logic        mem_done,
  output logic        mem_stall,
  input  logic [7:0]  ram_din,
  output logic [7:0]  ram_dout,
  output logic [31:0] ram_a,
  output logic        ram_wr
);

  typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

  state_t      state_q, state_d;
  logic [2:0]  k_q, k_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [31:0] buf_q, buf_d;
  logic        frz_q, frz_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic [31:0] mem_rdata_q, mem_rdata_d;
  logic [31:0] ram_a_q, ram_a_d;
  logic [7:0]  ram_dout_q, ram_dout_d;
  logic        ram_wr_q, ram_wr_d;
  logic        if_done_q, if_done_d;
  logic        mem_done_q, mem_done_d;

  logic [1:0]  k_prev;
  logic [2:0]  k_next;
  logic [31:0] cap_word;
  logic [7:0]  wr_byte;
  logic [2:0]  mem_n;

  // Datapath helpers: the byte on ram_din belongs to index k-1, because the
  // RAM returns data one cycle after the address it was given.
  always_comb begin
    k_prev   = k_q[1:0] - 2'd1;
    k_next   = k_q + 3'd1;
    cap_word = buf_q;
    cap_word[{k_prev, 3'b000} +: 8] = ram_din;
    wr_byte  = wdata_q[{k_next[1:0], 3'b000} +: 8];
    case (mem_size)
      2'd0:    mem_n = 3'd1;
      2'd1:    mem_n = 3'd2;
      default: mem_n = 3'd4;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    k_d         = k_q;
    n_d         = n_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    frz_d       = frz_q;
    if_inst_d   = if_inst_q;
    mem_rdata_d = mem_rdata_q;
    ram_a_d     = ram_a_q;
    ram_dout_d  = ram_dout_q;
    ram_wr_d    = ram_wr_q;
    if_done_d   = if_done_q;
    mem_done_d  = mem_done_q;

    if (rdy) begin
      if_done_d  = 1'b0;
      mem_done_d = 1'b0;
      case (state_q)
        IDLE: begin
          // A request still held during its own done cycle must not restart.
          if (!if_done_q && !mem_done_q) begin
            if (mem_req) begin
              base_d  = mem_addr;
              ram_a_d = mem_addr;
              k_d     = 3'd0;
              buf_d   = 32'd0;
              n_d     = mem_n;
              if (mem_we) begin
                state_d    = MEM_WR;
                wdata_d    = mem_wdata;
                ram_dout_d = mem_wdata[7:0];
                ram_wr_d   = 1'b1;
              end else begin
                state_d = MEM_RD;
              end
            end else if (if_req && !jump) begin
              state_d = IF_RD;
              base_d  = if_addr;
              ram_a_d = if_addr;
              k_d     = 3'd0;
              buf_d   = 32'd0;
              n_d     = 3'd4;
            end
          end
        end
        IF_RD, MEM_RD: begin
          if (state_q == IF_RD && jump) begin
            state_d = IDLE;
            k_d     = 3'd0;
            frz_d   = 1'b0;
          end else if (frz_q) begin
            // Bytes in flight during the freeze are untrustworthy: start over.
            frz_d   = 1'b0;
            k_d     = 3'd0;
            ram_a_d = base_q;
            buf_d   = 32'd0;
          end else begin
            ram_a_d = ram_a_q + 32'd1;
            k_d     = k_next;
            if (k_q != 3'd0) buf_d = cap_word;
            if (k_q == n_q) begin
              state_d = IDLE;
              k_d     = 3'd0;
              if (state_q == IF_RD) begin
                if_inst_d = cap_word;
                if_done_d = 1'b1;
              end else begin
                mem_rdata_d = cap_word;
                mem_done_d  = 1'b1;
              end
            end
          end
        end
        MEM_WR: begin
          if (k_q == n_q - 3'd1) begin
            ram_wr_d   = 1'b0;
            mem_done_d = 1'b1;
            state_d    = IDLE;
            k_d        = 3'd0;
          end else begin
            k_d        = k_next;
            ram_a_d    = ram_a_q + 32'd1;
            ram_dout_d = wr_byte;
          end
        end
        default: state_d = IDLE;
      endcase
    end else if (state_q == IF_RD || state_q == MEM_RD) begin
      frz_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      k_q         <= 3'd0;
      n_q         <= 3'd0;
      base_q      <= 32'd0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      frz_q       <= 1'b0;
      if_inst_q   <= 32'd0;
      mem_rdata_q <= 32'd0;
      ram_a_q     <= 32'd0;
      ram_dout_q  <= 8'd0;
      ram_wr_q    <= 1'b0;
      if_done_q   <= 1'b0;
      mem_done_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      k_q         <= k_d;
      n_q         <= n_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      buf_q       <= buf_d;
      frz_q       <= frz_d;
      if_inst_q   <= if_inst_d;
      mem_rdata_q <= mem_rdata_d;
      ram_a_q     <= ram_a_d;
      ram_dout_q  <= ram_dout_d;
      ram_wr_q    <= ram_wr_d;
      if_done_q   <= if_done_d;
      mem_done_q  <= mem_done_d;
    end
  end

  assign if_inst   = if_inst_q;
  assign if_done   = if_done_q;
  assign mem_rdata = mem_rdata_q;
  assign mem_done  = mem_done_q;
  assign ram_a     = ram_a_q;
  assign ram_dout  = ram_dout_q;
  // A frozen write keeps its byte registered but must not reach the RAM.
  assign ram_wr    = ram_wr_q & rdy;
  assign if_stall  = if_req & ~if_done_q;
  assign mem_stall = mem_req & ~mem_done_q;

endmodule

// File: doc/mem_ctrl.md
# mem_ctrl

Byte-serial memory controller between the pipeline and the 8-bit unified RAM port. It accepts instruction fetches from IF and loads/stores from MEM, and serialises each one into 1, 2 or 4 byte accesses. It returns little-endian assembled data and produces the `if_stall` / `mem_stall` requests consumed by the stall controller. MEM traffic has priority over IF traffic, and IF fetches can be cancelled by a branch flush.

## Interface
Parameters: none.
- `clk`  in  1  system clock, all state on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `rdy`  in  1  global ready; low = freeze
- `jump`  in  1  flush; cancels any pending/in-flight IF fetch
- `if_req`  in  1  fetch request, held until `if_done`
- `if_addr`  in  32  fetch address (word fetch, 4 bytes)
- `if_inst`  out  32  fetched instruction, valid while `if_done`=1, held after
- `if_done`  out  1  one-cycle fetch-complete pulse
- `if_stall`  out  1  `if_req & ~if_done`
- `mem_req`  in  1  load/store request, held until `mem_done`
- `mem_we`  in  1  1 = store, 0 = load
- `mem_size`  in  2  0 = byte, 1 = half, 2 = word; 3 is treated as word
- `mem_addr`  in  32  data address
- `mem_wdata`  in  32  store data, low bytes used
- `mem_rdata`  out  32  load data, zero-extended; valid while `mem_done`=1, held after
- `mem_done`  out  1  one-cycle load/store-complete pulse
- `mem_stall`  out  1  `mem_req & ~mem_done`
- `ram_din`  in  8  RAM read data; the byte addressed at edge E appears before edge E+1
- `ram_dout`  out  8  RAM write data
- `ram_a`  out  32  RAM byte address
- `ram_wr`  out  1  RAM write enable; RAM writes at the edge ending a cycle with `ram_wr`=1

## Operation
- FSM states: IDLE, IF_RD, MEM_RD, MEM_WR. A byte index `k` (0..n) selects the current byte. n = 4 for IF; n = 1/2/4 from `mem_size` for MEM.
- In IDLE, a request is sampled only if no done pulse is high this cycle. Priority: `mem_req` over `if_req`. `if_req` is ignored when `jump`=1.
- Addressing: `ram_a` = base + k. Wraps modulo 2^32.
- Read (IF_RD/MEM_RD):
  - `ram_a` is registered and advances by 1 each cycle.
  - Byte k is captured from `ram_din` into bits [8k+7:8k] two edges after `ram_a` was set to base+k.
  - After byte n-1 is captured, assert done and return to IDLE. Unused upper bytes are 0.
- Write (MEM_WR):
  - Each cycle drive `ram_a` = base+k, `ram_dout` = wdata[8k+7:8k], `ram_wr` = 1.
  - After n bytes, `ram_wr` returns to 0, `mem_done` pulses, and the FSM returns to IDLE.
- In-flight IF is never preempted by MEM; MEM waits. `mem_stall` stays high meanwhile.
- `jump`=1 in IF_RD: abort and go to IDLE next edge. No `if_done`; `if_inst` is unchanged. `jump` has no effect on MEM states.
- `rdy`=0: all registers hold, except `ram_wr` is forced 0.
  - On resume, a read restarts from k=0.
  - On resume, a write continues at the current k (bytes already written are kept).
- Reset (async, any state): state IDLE, k=0, and `if_inst`, `mem_rdata`, `ram_a`, `ram_dout` = 0. `ram_wr`, `if_done`, `mem_done` = 0.

## Timing
Request is sampled in cycle 0 (IDLE, `rdy`=1).
- Read of n bytes: `ram_a`=base in cycle 1, base+k in cycle k+1. Done high in cycle n+2.
  - Word read (IF or load): done in cycle 6.
  - Half read: done in cycle 4.
  - Byte read: done in cycle 3.
- Write of n bytes: `ram_wr`=1 in cycles 1..n. Done high in cycle n+1, with `ram_wr`=0.
  - Word store: `ram_wr`=1 in cycles 1..4, done in cycle 5.
  - Byte store: `ram_wr`=1 in cycle 1, done in cycle 2.
- Done pulse lasts exactly 1 cycle. The next request is sampled no earlier than done+1.
- Stall outputs are combinational from inputs and the registered done. They drop in the done cycle.

## Test plan
- Reset mid-read: reset asserted in cycle 3 of a word fetch -> immediate IDLE; all outputs 0; no `if_done`.
- IF fetch: RAM[0x100..0x103] = 13,05,A0,00; `if_req`, addr 0x100 -> `if_inst`=0x00A00513 with `if_done` in cycle 6; `if_stall` high in cycles 0–5.
- Simultaneous requests: `if_req`@0x0 and load-word `mem_req`@0x1000 in the same cycle -> `mem_done` in cycle 6; IF sampled in cycle 7, `if_done` in cycle 13.
- Store byte then load half: store 0xAB to 0x20 -> `ram_wr` for 1 cycle, `ram_a`=0x20, `ram_dout`=0xAB, done in cycle 2. Load-half 0x20 (RAM[0x21]=0xCD) -> `mem_rdata`=0x0000CDAB.
- Flush: `jump` in cycle 3 of an IF_RD -> IDLE in cycle 4; no `if_done`; a new fetch starts normally afterwards.
- `rdy` drop: `rdy`=0 for 2 cycles during a word store at k=2 -> `ram_wr`=0 while low; bytes 2–3 written after resume; RAM holds the full word. The same drop during a read -> the read restarts and still returns the correct word.
